// File: rtl/uart_arb_pkg.sv
// Shared types and helpers for the UART transmit arbiter: FSM state encoding
// and the pointer/counter width function.
package uart_arb_pkg;

  localparam logic [2:0] IDLE      = 3'd0;
  localparam logic [2:0] SEND      = 3'd1;
  localparam logic [2:0] START     = 3'd2;
  localparam logic [2:0] WAIT_BUSY = 3'd3;
  localparam logic [2:0] WAIT_DONE = 3'd4;

  typedef enum logic [2:0] {
    ST_IDLE      = IDLE,
    ST_SEND      = SEND,
    ST_START     = START,
    ST_WAIT_BUSY = WAIT_BUSY,
    ST_WAIT_DONE = WAIT_DONE
  } state_t;

  // Never returns less than 1 so a single requester still gets a legal vector.
  function automatic int clog2(input int n);
    int w;
    w = 1;
    while ((1 << w) < n) w++;
    return w;
  endfunction

endpackage

// File: rtl/rr_picker.sv
// Rotate-priority encoder: grants the first set req bit at or after ptr,
// wrapping around, as a one-hot vector.
module rr_picker
  import uart_arb_pkg::*;
#(
  parameter int NUM_REQ = 2,
  localparam int PTR_W  = clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [PTR_W-1:0]   ptr,
  output logic [NUM_REQ-1:0] gnt,
  output logic               any
);

  logic [NUM_REQ-1:0] w_rot;
  logic [NUM_REQ-1:0] w_rot_oh;

  // Rotate so ptr lands on bit 0, keep the lowest set bit, rotate back.
  assign w_rot    = (req >> ptr) | (req << (NUM_REQ - int'(ptr)));
  assign w_rot_oh = w_rot & (~w_rot + NUM_REQ'(1));
  assign gnt      = (w_rot_oh << ptr) | (w_rot_oh >> (NUM_REQ - int'(ptr)));
  assign any      = |req;

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin, packet-granular arbiter sharing one UART TX core between
// NUM_REQ byte-stream requesters; the grant is held until the last byte has left.
module uart_tx_arbiter
  import uart_arb_pkg::*;
#(
  parameter int NUM_REQ  = 2,
  parameter int DATA_W   = 8,
  parameter int HOLD_MAX = 1023
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [NUM_REQ*DATA_W-1:0] req_data,
  input  logic [NUM_REQ-1:0]        req_last,
  output logic [NUM_REQ-1:0]        req_ready,
  output logic [NUM_REQ-1:0]        grant,
  output logic                      tx_start,
  output logic [DATA_W-1:0]         tx_data,
  input  logic                      tx_busy,
  output logic                      abort
);

  localparam int PTR_W  = clog2(NUM_REQ);
  localparam int HOLD_W = clog2(HOLD_MAX + 1);

  state_t              r_state;
  state_t              w_next;
  logic [NUM_REQ-1:0]  r_grant;
  logic [PTR_W-1:0]    r_ptr;
  logic [DATA_W-1:0]   r_tx_data;
  logic                r_last;
  logic [HOLD_W-1:0]   r_hold;

  logic [NUM_REQ-1:0]  w_pick_gnt;
  logic                w_pick_any;
  logic                w_sel_valid;
  logic                w_sel_last;
  logic [DATA_W-1:0]   w_sel_data;
  logic [PTR_W-1:0]    w_ptr_adv;
  logic                w_hold_expired;

  rr_picker #(.NUM_REQ(NUM_REQ)) u_picker (
    .req (req_valid),
    .ptr (r_ptr),
    .gnt (w_pick_gnt),
    .any (w_pick_any)
  );

  // Owner's lane and the pointer one past the owner, selected by the one-hot grant.
  always_comb begin
    w_sel_valid = 1'b0;
    w_sel_last  = 1'b0;
    w_sel_data  = '0;
    w_ptr_adv   = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (r_grant[i]) begin
        w_sel_valid = req_valid[i];
        w_sel_last  = req_last[i];
        w_sel_data  = req_data[i*DATA_W +: DATA_W];
        w_ptr_adv   = PTR_W'((i + 1) % NUM_REQ);
      end
    end
  end

  assign w_hold_expired = (r_hold == HOLD_W'(HOLD_MAX));

  // NOTE: every output of this block gets a default first so no path can infer a latch.
  always_comb begin
    w_next    = r_state;
    req_ready = '0;
    tx_start  = 1'b0;
    abort     = 1'b0;
    case (r_state)
      ST_IDLE:      if (!tx_busy && w_pick_any) w_next = ST_SEND;
      ST_SEND: begin
        if (w_hold_expired) begin
          abort  = 1'b1;
          w_next = ST_IDLE;
        end else if (w_sel_valid) begin
          req_ready = r_grant;
          w_next    = ST_START;
        end
      end
      ST_START: begin
        tx_start = 1'b1;
        w_next   = ST_WAIT_BUSY;
      end
      ST_WAIT_BUSY: if (tx_busy) w_next = ST_WAIT_DONE;
      ST_WAIT_DONE: if (!tx_busy) w_next = r_last ? ST_IDLE : ST_SEND;
      default:      w_next = ST_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state   <= ST_IDLE;
      r_grant   <= '0;
      r_ptr     <= '0;
      r_tx_data <= '0;
      r_last    <= 1'b0;
      r_hold    <= '0;
    end else begin
      r_state <= w_next;
      case (r_state)
        ST_IDLE: begin
          if (w_next == ST_SEND) r_grant <= w_pick_gnt;
          r_hold <= '0;
        end
        ST_SEND: begin
          if (w_hold_expired) begin
            r_grant <= '0;
            r_ptr   <= w_ptr_adv;
          end else if (w_sel_valid) begin
            r_tx_data <= w_sel_data;
            r_last    <= w_sel_last;
            r_hold    <= '0;
          end else begin
            r_hold <= r_hold + HOLD_W'(1);
          end
        end
        ST_WAIT_DONE: begin
          if (!tx_busy) begin
            r_hold <= '0;
            if (r_last) begin
              r_grant <= '0;
              r_ptr   <= w_ptr_adv;
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign grant   = r_grant;
  assign tx_data = r_tx_data;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Scoreboard bench for uart_tx_arbiter: a round-robin packet model fills the
// expected queue, a monitor pops it on every tx_start.
module tb_uart_tx_arbiter;

  localparam int NUM_REQ  = 2;
  localparam int DATA_W   = 8;
  localparam int HOLD_MAX = 8;
  localparam int TO       = 3000;

  typedef struct {
    logic [DATA_W-1:0] data;
    logic              last;
  } byte_t;

  typedef struct {
    logic [NUM_REQ-1:0] gnt;
    logic [DATA_W-1:0]  data;
  } exp_t;

  logic                      clk = 1'b0;
  logic                      rst_n;
  logic [NUM_REQ-1:0]        req_valid;
  logic [NUM_REQ*DATA_W-1:0] req_data;
  logic [NUM_REQ-1:0]        req_last;
  logic [NUM_REQ-1:0]        req_ready;
  logic [NUM_REQ-1:0]        grant;
  logic                      tx_start;
  logic [DATA_W-1:0]         tx_data;
  logic                      tx_busy;
  logic                      abort;

  logic              drv_valid [NUM_REQ];
  logic [DATA_W-1:0] drv_data  [NUM_REQ];
  logic              drv_last  [NUM_REQ];

  byte_t pkt_q [NUM_REQ][$];
  exp_t  sb_q [$];
  int    start_cycles [$];

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;
  int busy_cnt = 0;
  int busy_len = 10;
  bit rand_busy = 0;
  bit gaps_on = 0;
  bit abort_ok = 0;
  int model_ptr = 0;
  int drivers_active = 0;

  uart_tx_arbiter #(.NUM_REQ(NUM_REQ), .DATA_W(DATA_W), .HOLD_MAX(HOLD_MAX)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_data  (req_data),
    .req_last  (req_last),
    .req_ready (req_ready),
    .grant     (grant),
    .tx_start  (tx_start),
    .tx_data   (tx_data),
    .tx_busy   (tx_busy),
    .abort     (abort)
  );

  always #5 clk = ~clk;

  always_comb begin
    req_valid = '0;
    req_data  = '0;
    req_last  = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      req_valid[i]                  = drv_valid[i];
      req_data[i*DATA_W +: DATA_W]  = drv_data[i];
      req_last[i]                   = drv_last[i];
    end
  end

  // TX core stub: busy starts the cycle after tx_start and lasts busy_len cycles.
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (tx_start) busy_cnt <= rand_busy ? int'($urandom_range(12, 1)) : busy_len;
    else if (busy_cnt > 0) busy_cnt <= busy_cnt - 1;
  end
  assign tx_busy = (busy_cnt != 0);

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic fail(input string name);
    vectors++;
    miscompares++;
    $display("FAIL %s: timed out (t=%0t)", name, $time);
  endtask

  task automatic add_byte(input int r, input logic [DATA_W-1:0] d, input logic l);
    byte_t b;
    b.data = d;
    b.last = l;
    pkt_q[r].push_back(b);
  endtask

  task automatic push_exp(input logic [NUM_REQ-1:0] g, input logic [DATA_W-1:0] d);
    exp_t e;
    e.gnt  = g;
    e.data = d;
    sb_q.push_back(e);
  endtask

  // Reference: whole packets served round-robin among requesters that still have packets.
  task automatic model_run();
    int  pos [NUM_REQ];
    int  pick;
    bit  lst;
    for (int r = 0; r < NUM_REQ; r++) pos[r] = 0;
    forever begin
      pick = -1;
      for (int k = 0; k < NUM_REQ; k++) begin
        int r;
        r = (model_ptr + k) % NUM_REQ;
        if (pick < 0 && pos[r] < pkt_q[r].size()) pick = r;
      end
      if (pick < 0) break;
      do begin
        push_exp(NUM_REQ'(1) << pick, pkt_q[pick][pos[pick]].data);
        lst = pkt_q[pick][pos[pick]].last;
        pos[pick]++;
      end while (!lst && pos[pick] < pkt_q[pick].size());
      model_ptr = (pick + 1) % NUM_REQ;
    end
  endtask

  task automatic wait_ready(input int r, output bit ok);
    int t;
    t = 0;
    #1;
    while (!req_ready[r] && t < TO) begin
      @(negedge clk);
      #1;
      t++;
    end
    ok = (t < TO);
    if (!ok) fail($sformatf("handshake_req%0d", r));
  endtask

  task automatic drive(input int r);
    byte_t b;
    bit    first;
    bit    ok;
    first = 1;
    while (pkt_q[r].size() != 0) begin
      b = pkt_q[r].pop_front();
      if (!first && gaps_on) begin
        drv_valid[r] = 1'b0;
        repeat ($urandom_range(3, 0)) @(negedge clk);
      end
      drv_valid[r] = 1'b1;
      drv_data[r]  = b.data;
      drv_last[r]  = b.last;
      wait_ready(r, ok);
      if (!ok) begin
        pkt_q[r].delete();
        break;
      end
      @(posedge clk);
      first = b.last;
      @(negedge clk);
    end
    drv_valid[r] = 1'b0;
    drivers_active--;
  endtask

  task automatic start_drivers();
    for (int r = 0; r < NUM_REQ; r++) begin
      automatic int rr = r;
      drivers_active++;
      fork
        drive(rr);
      join_none
    end
  endtask

  task automatic wait_idle();
    int t;
    t = 0;
    while (!(drivers_active == 0 && sb_q.size() == 0 && grant == '0 && !tx_busy) && t < TO) begin
      @(negedge clk);
      t++;
    end
    if (t >= TO) begin
      fail("wait_idle");
      sb_q.delete();
    end
    repeat (2) @(negedge clk);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    for (int r = 0; r < NUM_REQ; r++) drv_valid[r] = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    model_ptr = 0;
  endtask

  // Monitor: decoupled from stimulus, pops one expectation per transmitted byte.
  always @(negedge clk) begin
    if (rst_n) begin
      if (tx_start) begin
        start_cycles.push_back(cyc);
        if (sb_q.size() == 0) begin
          check("unexpected_tx_start_data", 32'(tx_data), 32'hFFFF_FFFF);
        end else begin
          exp_t e;
          e = sb_q.pop_front();
          check("tx_data", 32'(tx_data), 32'(e.data));
          check("tx_grant", 32'(grant), 32'(e.gnt));
        end
      end
      if ($countones(req_ready) > 1 || (req_ready & ~grant) != '0)
        check("req_ready_owner_only", 32'(req_ready), 32'(req_ready & grant));
      if (abort && !abort_ok) check("unexpected_abort", 32'(abort), 32'd0);
    end
  end

  initial begin
    int t;
    int k;
    int bad;
    bit ok;
    rst_n = 1'b0;
    for (int r = 0; r < NUM_REQ; r++) begin
      drv_valid[r] = 1'b0;
      drv_data[r]  = '0;
      drv_last[r]  = 1'b0;
    end
    repeat (3) @(negedge clk);
    check("rst_grant", 32'(grant), 32'd0);
    check("rst_req_ready", 32'(req_ready), 32'd0);
    check("rst_tx_start", 32'(tx_start), 32'd0);
    check("rst_tx_data", 32'(tx_data), 32'd0);
    check("rst_abort", 32'(abort), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // Single requester: latency, byte order, 13-cycle byte spacing with 10-cycle busy.
    start_cycles.delete();
    add_byte(0, 8'h55, 1'b0);
    add_byte(0, 8'hA3, 1'b1);
    model_run();
    start_drivers();
    @(negedge clk);
    check("lat_grant", 32'(grant), 32'd1);
    check("lat_req_ready", 32'(req_ready), 32'd1);
    @(negedge clk);
    check("lat_tx_start", 32'(tx_start), 32'd1);
    wait_idle();
    check("single_grant_cleared", 32'(grant), 32'd0);
    check("tx_start_count", 32'(start_cycles.size()), 32'd2);
    if (start_cycles.size() == 2)
      check("tx_start_spacing", 32'(start_cycles[1] - start_cycles[0]), 32'd13);

    // Contention from rr_ptr=0; req0 re-raises and must wait for req1's packet.
    do_reset();
    add_byte(0, 8'h10, 1'b0);
    add_byte(0, 8'h11, 1'b1);
    add_byte(0, 8'h12, 1'b1);
    add_byte(1, 8'h20, 1'b0);
    add_byte(1, 8'h21, 1'b1);
    model_run();
    start_drivers();
    wait_idle();

    // Fairness: continuous one-byte packets from both requesters alternate.
    do_reset();
    for (int i = 0; i < 6; i++) begin
      add_byte(0, DATA_W'(8'h30 + i), 1'b1);
      add_byte(1, DATA_W'(8'h40 + i), 1'b1);
    end
    model_run();
    start_drivers();
    wait_idle();

    // Randomized packets, inter-byte gaps and frame lengths.
    gaps_on = 1;
    rand_busy = 1;
    for (int it = 0; it < 8; it++) begin
      for (int r = 0; r < NUM_REQ; r++) begin
        int npk;
        npk = $urandom_range(3, 0);
        for (int p = 0; p < npk; p++) begin
          int len;
          len = $urandom_range(4, 1);
          for (int b = 0; b < len; b++)
            add_byte(r, DATA_W'($urandom_range(255, 0)), (b == len - 1));
        end
      end
      model_run();
      start_drivers();
      wait_idle();
    end
    gaps_on = 0;
    rand_busy = 0;

    // Stall abort: req1 owns after req0's packet, sends a non-last byte, then stalls.
    do_reset();
    add_byte(0, 8'h66, 1'b1);
    model_run();
    start_drivers();
    wait_idle();
    push_exp(2'b10, 8'h3C);
    abort_ok = 1;
    drv_data[1]  = 8'h3C;
    drv_last[1]  = 1'b0;
    drv_valid[1] = 1'b1;
    wait_ready(1, ok);
    @(posedge clk);
    @(negedge clk);
    drv_valid[1] = 1'b0;
    t = 0;
    while (!tx_busy && t < TO) begin @(negedge clk); t++; end
    while (tx_busy && t < TO) begin @(negedge clk); t++; end
    if (t >= TO) fail("abort_busy_wait");
    k = 0;
    while (!abort && k < 30) begin @(negedge clk); k++; end
    check("abort_delay", 32'(k), 32'd9);
    check("abort_owner", 32'(grant), 32'b10);
    @(negedge clk);
    check("abort_one_cycle", 32'(abort), 32'd0);
    check("abort_grant_cleared", 32'(grant), 32'd0);
    abort_ok = 0;
    model_ptr = 0;
    add_byte(0, 8'h44, 1'b1);
    add_byte(1, 8'h77, 1'b1);
    model_run();
    start_drivers();
    wait_idle();

    // Reset in WAIT_DONE with a 20-cycle frame: no grant until the line is free.
    busy_len = 20;
    push_exp(2'b01, 8'h5A);
    push_exp(2'b01, 8'h5B);
    drv_data[0]  = 8'h5A;
    drv_last[0]  = 1'b0;
    drv_valid[0] = 1'b1;
    wait_ready(0, ok);
    @(posedge clk);
    @(negedge clk);
    drv_data[0] = 8'h5B;
    drv_last[0] = 1'b1;
    t = 0;
    while (!tx_busy && t < TO) begin @(negedge clk); t++; end
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    check("midrst_grant", 32'(grant), 32'd0);
    check("midrst_req_ready", 32'(req_ready), 32'd0);
    check("midrst_tx_start", 32'(tx_start), 32'd0);
    check("midrst_tx_data", 32'(tx_data), 32'd0);
    check("midrst_abort", 32'(abort), 32'd0);
    check("midrst_busy_held", 32'(tx_busy), 32'd1);
    bad = 0;
    t = 0;
    while (tx_busy && t < 40) begin
      if (grant != '0) bad++;
      @(negedge clk);
      t++;
    end
    check("midrst_no_grant_while_busy", 32'(bad), 32'd0);
    wait_ready(0, ok);
    @(posedge clk);
    @(negedge clk);
    drv_valid[0] = 1'b0;
    wait_idle();

    check("scoreboard_drained", 32'(sb_q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
